// File: rtl/toi2s_pkg.sv
// ---------------------------------------------------------------------------
// toi2s_pkg
// Shared types and helpers for the multi-channel PWM output stage.
//   state_t     : amplifier power/gain state (OFF, RAMP_UP, RUN, RAMP_DOWN)
//   MODE_EDGE   : mode input value for edge-aligned modulation
//   MODE_CENTRE : mode input value for centre-aligned modulation
//   centre_lo() : first counter value of the high window in centre mode
// ---------------------------------------------------------------------------
package toi2s_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTRE = 1'b1;

    // The high window of length duty is centred in a frame of 2^width
    // cycles; any odd leftover cycle ends up after the window.
    function automatic int centre_lo(input int duty, input int width);
        return ((1 << width) - duty) >>> 1;
    endfunction

endpackage

// File: rtl/toi2s_pwm_mc_if.sv
// ---------------------------------------------------------------------------
// toi2s_pwm_mc_if
// Sample stream into the PWM output stage (valid/ready handshake).
//   s_valid : sample word valid (source -> stage)
//   s_ready : stage can accept the word this cycle (stage -> source)
//   s_data  : NCH signed samples, channel c in bits [c*WIDTH +: WIDTH]
// Modports: master = sample source, slave = PWM stage.
// ---------------------------------------------------------------------------
interface toi2s_pwm_mc_if #(
    parameter int NCH   = 2,
    parameter int WIDTH = 8
) ();

    logic                   s_valid;
    logic                   s_ready;
    logic [NCH*WIDTH-1:0]   s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/toi2s_pwm_chan.sv
// ---------------------------------------------------------------------------
// toi2s_pwm_chan
// One PWM channel: scales the frame's sample by the ramp gain into a duty
// value (registered at the frame boundary) and compares it against the
// shared frame counter, giving a registered PWM output.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : frame boundary, capture the new duty
//   sample     : signed sample that will play in the next frame
//   gain       : gain that will apply in the next frame (0..2^GAIN_W)
//   cnt        : shared frame counter
//   mode       : MODE_EDGE / MODE_CENTRE for the current frame
//   off        : stage is OFF, hold the output low
//   pwm_out    : PWM output, one cycle behind cnt
// ---------------------------------------------------------------------------
module toi2s_pwm_chan
    import toi2s_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int GAIN_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic signed [WIDTH-1:0] sample,
    input  logic [GAIN_W:0]         gain,
    input  logic [WIDTH-1:0]        cnt,
    input  logic                    mode,
    input  logic                    off,
    output logic                    pwm_out
);

    localparam int PW = WIDTH + GAIN_W + 2;
    localparam int LW = WIDTH + 1;
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]      duty_q;
    logic [WIDTH-1:0]      duty_d;
    logic signed [PW-1:0]  sample_x;
    logic signed [PW-1:0]  gain_x;
    logic signed [PW-1:0]  prod;
    logic [LW-1:0]         lo;
    logic [LW-1:0]         hi;
    logic [LW-1:0]         cnt_x;
    logic                  hit;

    // Scaled sample lies in -2^(WIDTH-1)..2^(WIDTH-1)-1, so adding the
    // mid-scale offset modulo 2^WIDTH is just an MSB flip.
    always_comb begin
        sample_x = PW'(sample);
        gain_x   = PW'({1'b0, gain});
        prod     = sample_x * gain_x;
        duty_d   = WIDTH'(prod >>> GAIN_W) ^ HALF;
    end

    // Window bounds are one bit wider so lo+duty cannot wrap.
    always_comb begin
        lo    = LW'(centre_lo(int'(duty_q), WIDTH));
        hi    = lo + {1'b0, duty_q};
        cnt_x = {1'b0, cnt};
        if (mode == MODE_CENTRE) begin
            hit = (cnt_x >= lo) && (cnt_x < hi);
        end else begin
            hit = (cnt < duty_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_q  <= HALF;
            pwm_out <= 1'b0;
        end else begin
            if (load) begin
                duty_q <= duty_d;
            end
            pwm_out <= hit && !off;
        end
    end

endmodule

// File: rtl/toi2s_pwm_mc.sv
// ---------------------------------------------------------------------------
// toi2s_pwm_mc
// Multi-channel audio PWM output stage with pop-free gain ramping.
//   clk, rst_n  : clock, synchronous active-low reset
//   en          : amplifier enable request, acted on at frame boundaries
//   mode        : 0 edge-aligned, 1 centre-aligned, taken at frame boundaries
//   smp         : sample stream (toi2s_pwm_mc_if.slave)
//   pwm_out     : one PWM output per channel
//   nenable_out : active-low amplifier enable
//   nmute_out   : active-low mute (1 = unmuted)
//   underrun    : one-cycle pulse when a frame starts without a new sample
//   frame_start : one-cycle pulse with the first pwm_out cycle of a frame
// A frame is 2^WIDTH cycles; the boundary is the cycle with cnt all ones.
// ---------------------------------------------------------------------------
module toi2s_pwm_mc
    import toi2s_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int WIDTH  = 8,
    parameter int GAIN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    toi2s_pwm_mc_if.slave    smp,
    output logic [NCH-1:0]   pwm_out,
    output logic             nenable_out,
    output logic             nmute_out,
    output logic             underrun,
    output logic             frame_start
);

    localparam logic [WIDTH-1:0]  CNT_LAST  = {WIDTH{1'b1}};
    localparam logic [GAIN_W:0]   GAIN_FULL = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0]   GAIN_ONE  = {{GAIN_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0]       cnt;
    logic                   boundary;
    logic                   live_q;
    logic                   full_q;
    logic                   hs;
    logic [NCH*WIDTH-1:0]   hold_q;
    logic [NCH*WIDTH-1:0]   sample_q;
    logic [NCH*WIDTH-1:0]   sample_new;
    state_t                 state_q;
    state_t                 state_nxt;
    logic [GAIN_W:0]        gain_q;
    logic [GAIN_W:0]        gain_nxt;
    logic                   mode_q;
    logic                   is_off;

    assign boundary = (cnt == CNT_LAST);
    assign is_off   = (state_q == OFF);

    // live_q keeps s_ready low until the first cycle after reset release.
    // At the boundary the hold entry drains, so a new word can always land.
    assign smp.s_ready = live_q && (!full_q || boundary);
    assign hs          = smp.s_valid && smp.s_ready;

    // Sample that plays in the next frame: buffered word first, then a
    // word arriving right at the boundary, otherwise repeat the last one.
    always_comb begin
        sample_new = sample_q;
        if (full_q) begin
            sample_new = hold_q;
        end else if (hs) begin
            sample_new = smp.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            frame_start <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            cnt         <= cnt + 1'b1;
            frame_start <= (cnt == '0);
            live_q      <= 1'b1;
        end
    end

    // Holding buffer and per-frame sample register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q   <= 1'b0;
            hold_q   <= '0;
            sample_q <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (boundary) begin
                sample_q <= sample_new;
                if (full_q) begin
                    if (hs) begin
                        hold_q <= smp.s_data;
                    end
                    full_q <= hs;
                end else if (!hs) begin
                    underrun <= !is_off;
                end
            end else if (hs) begin
                hold_q <= smp.s_data;
                full_q <= 1'b1;
            end
        end
    end

    // Gain/state transitions only happen at the boundary. A reversal of
    // direction holds the gain for that boundary.
    always_comb begin
        state_nxt = state_q;
        gain_nxt  = gain_q;
        if (boundary) begin
            unique case (state_q)
                OFF: begin
                    gain_nxt = '0;
                    if (en) begin
                        state_nxt = RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (!en) begin
                        state_nxt = RAMP_DOWN;
                    end else begin
                        gain_nxt = gain_q + 1'b1;
                        if (gain_q == GAIN_FULL - GAIN_ONE) begin
                            state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    gain_nxt = GAIN_FULL;
                    if (!en) begin
                        state_nxt = RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (en) begin
                        state_nxt = RAMP_UP;
                    end else if (gain_q <= GAIN_ONE) begin
                        gain_nxt  = '0;
                        state_nxt = OFF;
                    end else begin
                        gain_nxt = gain_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // Amplifier pins follow the next state so they switch together with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= OFF;
            gain_q      <= '0;
            mode_q      <= MODE_EDGE;
            nenable_out <= 1'b1;
            nmute_out   <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            gain_q      <= gain_nxt;
            if (boundary) begin
                mode_q <= mode;
            end
            nenable_out <= (state_nxt == OFF);
            nmute_out   <= (state_nxt != OFF);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        toi2s_pwm_chan #(
            .WIDTH  (WIDTH),
            .GAIN_W (GAIN_W)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (boundary),
            .sample  (sample_new[c*WIDTH +: WIDTH]),
            .gain    (gain_nxt),
            .cnt     (cnt),
            .mode    (mode_q),
            .off     (is_off),
            .pwm_out (pwm_out[c])
        );
    end

endmodule

// File: doc/toi2s_pwm_mc.md
Name: toi2s_pwm_mc

Overview:
Parametrised multi-channel audio PWM output stage for the toi2s chain; it generalises the single pwm_out path to NCH channels. It accepts signed samples over a valid/ready handshake and applies a per-frame linear gain ramp for pop-free enable and disable. It supports edge-aligned and centre-aligned modulation and drives the amplifier's nenable_out and nmute_out pins.

Parameters:
NCH, 2, number of audio channels
WIDTH, 8, sample width and PWM counter width; frame = 2^WIDTH clk cycles
GAIN_W, 4, gain fraction bits; GMAX = 2^GAIN_W; a full ramp takes GMAX frames

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
en  in  1  amplifier enable request; sampled only at frame boundary
mode  in  1  0 = edge-aligned, 1 = centre-aligned; sampled at frame boundary
s_valid  in  1  sample word valid
s_ready  out  1  sample word accepted when s_valid && s_ready
s_data  in  NCH*WIDTH  signed two's-complement samples; channel c in bits [c*WIDTH +: WIDTH]
pwm_out  out  NCH  PWM outputs
nenable_out  out  1  active-low amplifier enable
nmute_out  out  1  active-low mute (1 = unmuted)
underrun  out  1  one-cycle pulse when no sample is available at a boundary outside OFF
frame_start  out  1  one-cycle pulse aligned with the first pwm_out cycle of each frame

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - cnt=0, state OFF, gain=0, holding buffer empty, sample_q=0, duty_q=2^(WIDTH-1).
  - Outputs: pwm_out=0, nenable_out=1, nmute_out=0, underrun=0, frame_start=0, s_ready=0.
  - After reset releases, s_ready=1.
- Counter: cnt (WIDTH bits) free-runs in every state and wraps from 2^WIDTH-1 to 0. The boundary cycle is the cycle where cnt==2^WIDTH-1.
- Holding buffer: one entry of NCH samples.
  - s_ready = !full || boundary.
- At the boundary cycle, in priority order:
  - If full: sample_q <= hold. If a handshake also occurs this cycle, hold <= s_data and full stays 1; otherwise full <= 0.
  - If empty and a handshake occurs: sample_q <= s_data directly; no underrun.
  - If empty and no handshake: sample_q is kept (previous sample repeats). underrun pulses in the cycle cnt==0 if state != OFF.
- A handshake outside the boundary sets full=1 and writes hold.
- FSM (evaluated only at the boundary; gain update and state change happen together):
  - OFF: gain=0. en=1 -> RAMP_UP.
  - RAMP_UP: gain+1 per boundary. When gain reaches GMAX -> RUN. en=0 -> RAMP_DOWN; this takes precedence, and gain holds that boundary.
  - RUN: gain=GMAX. en=0 -> RAMP_DOWN.
  - RAMP_DOWN: gain-1 per boundary. When gain reaches 0 -> OFF. en=1 -> RAMP_UP from the current gain.
- Duty computation: duty_q[c] <= 2^(WIDTH-1) + ((sample_q_new[c] * gain_new) >>> GAIN_W), arithmetic shift, computed at the boundary. The range is 0..2^WIDTH-1 with no overflow; gain=0 gives 50% duty (silence).
- Compare, registered with one-cycle latency: pwm_out[c] <= cmp(cnt, duty_q[c], mode_q).
  - Edge-aligned: high when cnt < duty.
  - Centre-aligned: lo = (2^WIDTH - duty) >> 1; high when lo <= cnt < lo+duty.
  - Forced to 0 when state_q == OFF.
- frame_start is registered from cnt==0, so it aligns with pwm_out.
- nenable_out = (state == OFF). nmute_out = (state != OFF). Both are registered.
- A mid-operation reset aborts any ramp immediately; outputs take reset values on the next edge.

Decomposition:
- toi2s_pkg: state enum (OFF, RAMP_UP, RUN, RAMP_DOWN), MODE_EDGE/MODE_CENTRE constants, and the centre-offset function.
- Sub-module toi2s_pwm_chan: one instance per channel via generate. It contains the duty multiply/offset and the compare flop. The top level holds the counter, the buffer and the FSM.

Test Plan (NCH=2, WIDTH=8, GAIN_W=4):
1. Reset with en=0 -> pwm_out=00, nenable_out=1, nmute_out=0, s_ready=1 one cycle after release; frame_start pulses every 256 cycles.
2. en=1, samples ch0=+64 / ch1=-64 every frame, edge mode -> ramp frame k has ch0 high 128+4k cycles and ch1 high 128-4k; after 16 frames state is RUN with ch0=192 and ch1=64 high cycles.
3. Centre mode in RUN, ch1=-64 -> pwm_out[1] high for cnt 96..159 each frame.
4. Withhold one sample in RUN -> underrun high for exactly 1 cycle at cnt==0; duty repeats the previous values (192/64).
5. Drop en at gain 5 during RAMP_UP -> RAMP_DOWN over 5 frames, then OFF; pwm_out=0 and nenable_out=1 at the boundary reaching gain 0. Re-raise en at gain 3 -> ramp up resumes from 3.
6. RUN with ch0=-128, ch1=+127 -> ch0 constantly 0; ch1 high 255 of 256 cycles (edge). Assert rst_n=0 mid-frame -> all outputs take reset values on the next edge.
